// File: rtl/reverse_arbiter.sv
// Two-requester round-robin arbiter. The winning payload is latched at the
// grant edge, and the bit-reversed result is presented one cycle later.
// A modulo-256 completion counter is kept, with a wrap pulse and a clear.
module reverse_arbiter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req0,
  input  logic [W-1:0] data0,
  input  logic         req1,
  input  logic [W-1:0] data1,
  input  logic         clr,
  output logic         gnt0,
  output logic         gnt1,
  output logic         out_valid,
  output logic         out_id,
  output logic [W-1:0] out_data,
  output logic [7:0]   done_cnt,
  output logic         ov
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t       state;
  state_t       state_nx;
  logic         last;      // index of the requester served most recently
  logic         grant;     // a grant is issued at this edge
  logic         finish;    // a result is produced at this edge
  logic         win;       // index of this cycle's arbitration winner
  logic         lat_id;
  logic [W-1:0] lat_data;
  logic [W-1:0] rev_data;

  // State register; reset is synchronous and active-low.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of the order of the processes.
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic: a request moves IDLE to BUSY, and BUSY always returns.
  always_comb begin
    // NOTE: default first, so no path through the case leaves state_nx
    // unassigned and infers a latch.
    state_nx = state;
    case (state)
      IDLE:    if (req0 || req1) state_nx = BUSY;
      BUSY:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Output decode: the grant/finish strobes and the round-robin winner.
  always_comb begin
    grant  = 1'b0;
    finish = 1'b0;
    win    = 1'b0;
    case (state)
      IDLE: begin
        grant = req0 || req1;
        // Under contention the requester not served last wins; otherwise
        // the lone requester wins outright.
        if (req0 && req1) win = ~last;
        else              win = req1;
      end
      BUSY:    finish = 1'b1;
      default: ;
    endcase
  end

  // Bit-reverse the latched payload for the result register.
  always_comb begin
    rev_data = '0;
    for (int i = 0; i < W; i++) rev_data[i] = lat_data[W-1-i];
  end

  // Payload latch, loaded only at a grant edge.
  always_ff @(posedge clk) begin
    // NOTE: the payload latch has no reset; it is only read in BUSY, which
    // can only be entered through a grant edge that reloads it.
    if (grant) lat_data <= win ? data1 : data0;
  end

  // Grant pulses, winner bookkeeping and the result register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      last      <= 1'b1;
      lat_id    <= 1'b0;
      out_valid <= 1'b0;
      out_id    <= 1'b0;
      out_data  <= '0;
    end else begin
      gnt0      <= grant && !win;
      gnt1      <= grant && win;
      out_valid <= finish;
      if (grant) begin
        lat_id <= win;
        last   <= win;
      end
      if (finish) begin
        out_id   <= lat_id;
        out_data <= rev_data;
      end
    end
  end

  // Completion counter; clr wins over a simultaneous completion.
  always_ff @(posedge clk) begin
    if (!reset) begin
      done_cnt <= 8'h00;
      ov       <= 1'b0;
    end else if (clr) begin
      done_cnt <= 8'h00;
      ov       <= 1'b0;
    end else begin
      ov <= finish && (done_cnt == 8'hFF);
      if (finish) done_cnt <= done_cnt + 8'h01;
    end
  end

endmodule

// File: tb/tb_reverse_arbiter.sv
// Directed bench for reverse_arbiter. The stimulus pushes the expected
// results, each tagged with the edge that should produce it, into a
// scoreboard queue. Every clock edge is checked against that queue and
// against a small counter model.
module tb_reverse_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       req0;
  logic [7:0] data0;
  logic       req1;
  logic [7:0] data1;
  logic       clr;
  logic       gnt0;
  logic       gnt1;
  logic       out_valid;
  logic       out_id;
  logic [7:0] out_data;
  logic [7:0] done_cnt;
  logic       ov;

  typedef struct {
    int         cyc;
    logic       id;
    logic [7:0] data;
  } exp_t;

  exp_t       sb[$];
  int         cyc = 0;
  int         checks = 0;
  int         failures = 0;
  logic [7:0] exp_cnt = 8'h00;
  logic       exp_ov = 1'b0;
  logic       exp_v = 1'b0;
  logic       exp_id = 1'b0;
  logic [7:0] exp_data = 8'h00;
  logic       exp_g0 = 1'b0;
  logic       exp_g1 = 1'b0;

  reverse_arbiter #(.W(8)) dut (
    .clk(clk), .reset(reset), .req0(req0), .data0(data0), .req1(req1),
    .data1(data1), .clr(clr), .gnt0(gnt0), .gnt1(gnt1),
    .out_valid(out_valid), .out_id(out_id), .out_data(out_data),
    .done_cnt(done_cnt), .ov(ov)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] rev8(input logic [7:0] d);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = d[7-i];
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  // Advance one clock edge, update the expectation model, and check outputs
  // 1 time unit after the edge.
  task automatic tick();
    logic r;
    logic c;
    r = reset;
    c = clr;
    @(posedge clk);
    cyc++;
    #1;
    if (!r) begin
      sb.delete();
      exp_cnt  = 8'h00;
      exp_ov   = 1'b0;
      exp_v    = 1'b0;
      exp_id   = 1'b0;
      exp_data = 8'h00;
      exp_g0   = 1'b0;
      exp_g1   = 1'b0;
    end else begin
      exp_v  = 1'b0;
      exp_ov = 1'b0;
      if (sb.size() > 0 && sb[0].cyc == cyc) begin
        exp_v    = 1'b1;
        exp_id   = sb[0].id;
        exp_data = sb[0].data;
        void'(sb.pop_front());
        if (!c) begin
          exp_ov  = (exp_cnt == 8'hFF);
          exp_cnt = exp_cnt + 8'h01;
        end
      end
      if (c) begin
        exp_cnt = 8'h00;
        exp_ov  = 1'b0;
      end
      exp_g0 = (sb.size() > 0) && (sb[0].cyc == cyc + 1) && !sb[0].id;
      exp_g1 = (sb.size() > 0) && (sb[0].cyc == cyc + 1) && sb[0].id;
    end
    check("gnt0", 32'(gnt0), 32'(exp_g0));
    check("gnt1", 32'(gnt1), 32'(exp_g1));
    check("out_valid", 32'(out_valid), 32'(exp_v));
    check("out_id", 32'(out_id), 32'(exp_id));
    check("out_data", 32'(out_data), 32'(exp_data));
    check("done_cnt", 32'(done_cnt), 32'(exp_cnt));
    check("ov", 32'(ov), 32'(exp_ov));
  endtask

  // One single-requester transaction: request, grant edge, then the requester
  // drops req and the completion edge follows. c drives clr at that edge.
  task automatic txn(input logic id, input logic [7:0] d, input logic c);
    if (id) begin req1 = 1'b1; data1 = d; end
    else    begin req0 = 1'b1; data0 = d; end
    sb.push_back('{cyc + 2, id, rev8(d)});
    tick();
    req0 = 1'b0;
    req1 = 1'b0;
    clr  = c;
    tick();
    clr  = 1'b0;
  endtask

  initial begin
    int start;
    reset = 1'b0;
    req0  = 1'b0;
    req1  = 1'b0;
    data0 = 8'h00;
    data1 = 8'h00;
    clr   = 1'b0;

    // Reset held for two edges, then ten idle cycles with all outputs zero.
    tick();
    tick();
    reset = 1'b1;
    repeat (10) tick();

    // Single req0 with payload 0x01 gives result 0x80, id 0, count 1.
    txn(1'b0, 8'h01, 1'b0);
    tick();

    // A payload change after the grant edge must not reach the result.
    req0 = 1'b1;
    data0 = 8'h03;
    sb.push_back('{cyc + 2, 1'b0, 8'hC0});
    tick();
    data0 = 8'hFF;
    tick();
    req0 = 1'b0;
    tick();

    // A lone req1 wins outright; requester 1 becomes last-served.
    txn(1'b1, 8'h12, 1'b0);
    tick();

    // Both requests held continuously: grants alternate 0,1,0,...
    // with one result every two cycles.
    req0  = 1'b1;
    data0 = 8'h0F;
    req1  = 1'b1;
    data1 = 8'hF0;
    start = cyc;
    for (int k = 0; k < 8; k++)
      sb.push_back('{start + 2 + 2 * k, k[0], (k[0] ? 8'h0F : 8'hF0)});
    repeat (16) tick();
    req0 = 1'b0;
    req1 = 1'b0;
    repeat (2) tick();

    // A clear on the completion edge at count 5 wins: count 0, no ov,
    // and out_valid still pulses.
    reset = 1'b0;
    tick();
    reset = 1'b1;
    for (int k = 0; k < 5; k++) txn(k[0], 8'(k + 8'h21), 1'b0);
    txn(1'b0, 8'h6C, 1'b1);
    tick();

    // A clear while idle.
    clr = 1'b1;
    tick();
    clr = 1'b0;
    tick();

    // 255 completions reach 0xFF; the next one wraps to 0x00 with one ov pulse.
    for (int k = 0; k < 255; k++) txn(k[0], 8'($urandom_range(0, 255)), 1'b0);
    txn(1'b1, 8'hB4, 1'b0);
    repeat (3) tick();

    // Reset during BUSY after gnt1 drops the transaction; a later lone req1
    // is granted normally.
    req1  = 1'b1;
    data1 = 8'h5A;
    sb.push_back('{cyc + 2, 1'b1, 8'h5A});
    tick();
    req1  = 1'b0;
    reset = 1'b0;
    tick();
    reset = 1'b1;
    repeat (2) tick();
    txn(1'b1, 8'h81, 1'b0);
    repeat (2) tick();

    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reverse_arbiter.md
REVERSE_ARBITER -- requirements
Module: reverse_arbiter

Interface
REQ-001 Parameter: W, 8, data width of requester payloads and result.
REQ-002 clk  input  1  rising-edge system clock.
REQ-003 reset  input  1  synchronous, active-low; clock clk.
REQ-004 req0  input  1  requester 0 request, held high until gnt0 seen.
REQ-005 data0  input  W  requester 0 payload, stable while req0 high.
REQ-006 req1  input  1  requester 1 request, held high until gnt1 seen.
REQ-007 data1  input  W  requester 1 payload, stable while req1 high.
REQ-008 clr  input  1  synchronous clear of done_cnt.
REQ-009 gnt0  output  1  one-cycle registered grant pulse to requester 0.
REQ-010 gnt1  output  1  one-cycle registered grant pulse to requester 1.
REQ-011 out_valid  output  1  one-cycle pulse, result valid.
REQ-012 out_id  output  1  requester index owning current result.
REQ-013 out_data  output  W  bit-reversed payload: out_data[i] = payload[W-1-i].
REQ-014 done_cnt  output  8  count of completed transactions, modulo 256.
REQ-015 ov  output  1  one-cycle pulse when done_cnt wraps 0xFF->0x00.

Function
REQ-016 FSM SHALL have exactly two states, IDLE and BUSY, state register updated only on rising clk.
REQ-017 IDLE, no req: SHALL remain IDLE; gnt0/gnt1/out_valid low.
REQ-018 IDLE, any req: SHALL select winner, latch its payload and index, set winner's gnt for next cycle, move to BUSY.
REQ-019 Arbitration SHALL be round-robin: single req wins outright; both req -> requester not served last wins.
REQ-020 Last-served pointer SHALL update only on grant; reset value 1 (requester 0 first priority).
REQ-021 BUSY SHALL ignore req0/req1, load out_data with reversed latched payload, out_id with latched index, pulse out_valid, clear gnt, return to IDLE.
REQ-022 Latency: request sampled at edge t -> gnt high in cycle t..t+1 -> out_valid high in cycle t+1..t+2; throughput one transaction per 2 cycles.
REQ-023 gnt0 and gnt1 SHALL never be high together; at most one gnt per transaction.
REQ-024 out_data and out_id SHALL hold last result when out_valid low.
REQ-025 done_cnt SHALL increment by 1 in the cycle out_valid is loaded high; 0xFF+1 -> 0x00 with ov pulsed for that cycle only.
REQ-026 clr high SHALL set done_cnt to 0x00 and suppress ov, taking priority over a simultaneous completion.
REQ-027 Payload changes while req high after grant SHALL NOT affect result (latched at grant edge).

Reset
REQ-028 reset low at a rising edge SHALL force: state IDLE, gnt0=gnt1=0, out_valid=0, out_id=0, out_data=0, done_cnt=0, ov=0, last-served=1.
REQ-029 reset mid-transaction (BUSY) SHALL discard the latched payload; no out_valid and no done_cnt increment for it.
REQ-030 reset SHALL take priority over clr, req0, req1.

Verification
REQ-031 Reset held 2 cycles then released, no req -> all outputs 0 for 10 cycles.
REQ-032 req0=1, data0=0x01 -> gnt0 pulse one cycle, next cycle out_valid=1, out_id=0, out_data=0x80, done_cnt=1.
REQ-033 req0 and req1 held high continuously, data0=0x0F, data1=0xF0 -> grants alternate 0,1,0,1; results 0xF0 (id0), 0x0F (id1) alternating, one per 2 cycles.
REQ-034 255 completions then one more -> done_cnt 0xFF -> 0x00 with ov=1 for exactly one cycle.
REQ-035 clr asserted in same cycle as completion with done_cnt=0x05 -> done_cnt=0x00, ov=0, out_valid still pulses.
REQ-036 reset asserted during BUSY after gnt1 -> no out_valid, done_cnt=0, next req1 alone granted normally.
